// File: rtl/ula_pkg.sv
// Shared definitions for the sequenced ULA datapath: ULAControl op-codes,
// the sequencer state encoding and small op-classification helpers.
package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // Explicit 2-bit encoding keeps the state register compatible with the
  // board-level debug tooling that decodes it directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ULA_ADD) || (op == ULA_SUB);
  endfunction

endpackage

// File: rtl/ula_seq_datapath_reg_file.sv
// NREG x N register file: two async read ports, one async debug port, one
// synchronous write port, synchronous active-low clear, register 0 reads zero.
module reg_file #(
  parameter int N    = 8,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  input  logic [$clog2(NREG)-1:0] dbg_ra,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic                    we,
  input  logic [N-1:0]            wd,
  output logic [N-1:0]            rd1,
  output logic [N-1:0]            rd2,
  output logic [N-1:0]            dbg_rd
);

  logic [N-1:0] regs [NREG];

  // NOTE: the array is cleared by reset because the register bank must read
  // all-zero after reset; memories without that requirement stay unreset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Register 0 is forced to zero at the read side as well, so it stays zero
  // even if a synthesis flow keeps its flops.
  assign rd1    = (ra1    == '0) ? '0 : regs[ra1];
  assign rd2    = (ra2    == '0) ? '0 : regs[ra2];
  assign dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule

// File: rtl/ula_seq_datapath.sv
// Four-state (IDLE/READ/EXEC/WRITE) register-file + ULA datapath with a
// start/busy/done handshake. Define ULA_FLAGS_EN to build carry/ovf flags.
module ula_seq_datapath
  import ula_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  input  logic [$clog2(NREG)-1:0] wa3,
  input  logic [N-1:0]            imm,
  input  logic                    alusrc,
  input  logic                    we,
  output logic                    busy,
  output logic                    done,
  output logic [N-1:0]            result,
  output logic                    z,
  output logic                    neg,
  output logic                    carry,
  output logic                    ovf,
  input  logic [$clog2(NREG)-1:0] dbg_ra,
  output logic [N-1:0]            dbg_rd
);

  localparam int AW = $clog2(NREG);
`ifdef ULA_FLAGS_EN
  localparam int SW = N + 1;
`else
  localparam int SW = N;
`endif

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] wa_q;
  logic          we_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;

  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic          rf_we;

  logic          sub_sel;
  logic [N-1:0]  b_eff;
  logic [SW-1:0] sum_full;
  logic [N-1:0]  sum;
  logic          slt;
  logic [N-1:0]  alu_res;

  assign rf_we = (state == ST_WRITE) && we_q;

  reg_file #(
    .N    (N),
    .NREG (NREG)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .ra1    (ra1),
    .ra2    (ra2),
    .dbg_ra (dbg_ra),
    .wa     (wa_q),
    .we     (rf_we),
    .wd     (result),
    .rd1    (rd1),
    .rd2    (rd2),
    .dbg_rd (dbg_rd)
  );

  // SUB shares the adder as A + ~B + 1; the adder is one bit wider only when
  // the carry flag is built.
  always_comb begin
    sub_sel  = (op_q == ULA_SUB);
    b_eff    = sub_sel ? ~b_q : b_q;
    sum_full = SW'(a_q) + SW'(b_eff) + SW'(sub_sel);
    sum      = sum_full[N-1:0];
    slt      = $signed(a_q) < $signed(b_q);
    case (op_q)
      ULA_AND:          alu_res = a_q & b_q;
      ULA_OR:           alu_res = a_q | b_q;
      ULA_ADD, ULA_SUB: alu_res = sum;
      ULA_SLT:          alu_res = {{(N-1){1'b0}}, slt};
      default:          alu_res = '0;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      result <= '0;
      z      <= 1'b1;
      neg    <= 1'b0;
      op_q   <= '0;
      wa_q   <= '0;
      we_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            wa_q  <= wa3;
            we_q  <= we;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= rd1;
          b_q   <= alusrc ? imm : rd2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result <= alu_res;
          z      <= (alu_res == '0);
          neg    <= alu_res[N-1];
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ULA_FLAGS_EN
  logic carry_q;
  logic ovf_q;

  // Overflow on A + B_eff: operands agree in sign but the sum does not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == ST_EXEC) begin
      carry_q <= is_arith(op_q) && sum_full[N];
      ovf_q   <= is_arith(op_q) && (a_q[N-1] == b_eff[N-1]) && (sum[N-1] != a_q[N-1]);
    end
  end

  assign carry = carry_q;
  assign ovf   = ovf_q;
`else
  assign carry = 1'b0;
  assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_ula_seq_datapath.sv
// Scoreboard bench for ula_seq_datapath: stimulus pushes reference results,
// an independent monitor pops and compares on every done pulse.
module tb_ula_seq_datapath;

  localparam int N    = 8;
  localparam int NREG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [2:0] ra1 = '0, ra2 = '0, wa3 = '0, dbg_ra = '0;
  logic [7:0] imm = '0;
  logic       alusrc = 1'b0, we = 1'b0;
  logic       busy, done, z, neg, carry, ovf;
  logic [7:0] result, dbg_rd;

  ula_seq_datapath #(.N(N), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .imm(imm), .alusrc(alusrc), .we(we),
    .busy(busy), .done(done), .result(result),
    .z(z), .neg(neg), .carry(carry), .ovf(ovf),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       neg;
    logic       c;
    logic       v;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mregs[NREG];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ULA from plain integer arithmetic.
  function automatic exp_t ref_model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, s;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    e.c = 1'b0; e.v = 1'b0;
    case (o)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s = ua + ub;
        e.res = 8'(s % 256);
        e.c = (s > 255);
        e.v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'b110: begin
        s = ua - ub;
        e.res = 8'((s + 256) % 256);
        e.c = (ua >= ub);
        e.v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'b111: e.res = (sa < sb) ? 8'd1 : 8'd0;
      default: e.res = 8'd0;
    endcase
`ifndef ULA_FLAGS_EN
    e.c = 1'b0; e.v = 1'b0;
`endif
    e.z = (e.res == 8'd0);
    e.neg = e.res[7];
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 with no operation outstanding, expected done=0");
        end else begin
          e = sb_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("z", 32'(z), 32'(e.z));
          check("neg", 32'(neg), 32'(e.neg));
          check("carry", 32'(carry), 32'(e.c));
          check("ovf", 32'(ovf), 32'(e.v));
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] w, input logic [7:0] im, input logic src,
                       input logic wen, input bit poke);
    exp_t e;
    logic [7:0] bv;
    int edges;
    @(negedge clk);
    bv = src ? im : mregs[a2];
    e = ref_model(o, mregs[a1], bv);
    sb_q.push_back(e);
    if (wen && w != 3'd0) mregs[w] = e.res;
    op = o; ra1 = a1; ra2 = a2; wa3 = w; imm = im; alusrc = src; we = wen;
    start = 1'b1;
    @(posedge clk); #1;
    start = poke;
    check("busy_after_accept", 32'(busy), 32'd1);
    edges = 0;
    while (edges < 8) begin
      @(posedge clk); edges++; #1;
      if (edges >= 2) start = 1'b0;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    check("done_latency", 32'(edges), 32'd3);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic dbg_check(input logic [2:0] a);
    @(negedge clk);
    dbg_ra = a;
    #1;
    check("dbg_rd", 32'(dbg_rd), 32'(mregs[a]));
  endtask

  task automatic dbg_scan();
    for (int i = 0; i < NREG; i++) dbg_check(3'(i));
  endtask

  initial begin
    logic [2:0] op_tab[8];
    op_tab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < NREG; i++) mregs[i] = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_z", 32'(z), 32'd1);
    check("reset_neg", 32'(neg), 32'd0);
    check("reset_carry", 32'(carry), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    dbg_scan();

    do_op(3'b010, 3'd0, 3'd0, 3'd1, 8'h05, 1'b1, 1'b1, 1'b0);
    do_op(3'b010, 3'd1, 3'd0, 3'd2, 8'h07, 1'b1, 1'b1, 1'b0);
    dbg_check(3'd2);
    do_op(3'b110, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op(3'b010, 3'd0, 3'd0, 3'd4, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_op(3'b010, 3'd4, 3'd0, 3'd5, 8'h01, 1'b1, 1'b1, 1'b0);
    do_op(3'b111, 3'd5, 3'd0, 3'd6, 8'h01, 1'b1, 1'b1, 1'b0);
    do_op(3'b010, 3'd1, 3'd0, 3'd0, 8'h10, 1'b1, 1'b1, 1'b1);
    dbg_check(3'd0);
    do_op(3'b100, 3'd2, 3'd3, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0);
    dbg_scan();

    for (int n = 0; n < 40; n++) begin
      do_op(op_tab[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if (n % 8 == 7) dbg_scan();
    end

    // Make r1 nonzero and the result registers nonzero before the abort.
    do_op(3'b010, 3'd0, 3'd0, 3'd1, 8'h9A, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    op = 3'b010; ra1 = 3'd1; ra2 = 3'd0; wa3 = 3'd7; imm = 8'h11; alusrc = 1'b1; we = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_z", 32'(z), 32'd1);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", 32'(done), 32'd0);
    end
    dbg_scan();
    do_op(3'b010, 3'd0, 3'd0, 3'd1, 8'h03, 1'b1, 1'b1, 1'b0);
    dbg_check(3'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_seq_datapath.md
# ula_seq_datapath

Parametrised multi-cycle datapath: an NREG×N register file, a source mux (register or immediate) and the ULA, sequenced by a start/busy/done FSM. It is the next generation of the board-level register-bank and ULA test path. An operation reads two registers, executes, and writes back under handshake control. The debug read port lets the LCD/7-segment layer display any register without disturbing operation.

## Interface
- N, 8, datapath width in bits (≥4)
- NREG, 8, register count; power of two, ≥2; AW = $clog2(NREG) is derived, not a parameter
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request operation; sampled only in IDLE
- op  in  3  ULAControl: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); others reserved
- ra1, ra2, wa3  in  AW  source A, source B, destination addresses
- imm  in  N  immediate for SrcB
- alusrc  in  1  0: SrcB = rd2, 1: SrcB = imm
- we  in  1  write result to wa3 at end of operation
- busy  out  1  high from accept until the WRITE edge
- done  out  1  one-cycle pulse after write-back
- result  out  N  registered ULA result
- z, neg, carry, ovf  out  1  registered flags
- dbg_ra  in  AW  debug read address
- dbg_rd  out  N  combinational read of dbg_ra

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE→READ when start=1.
  - READ→EXEC.
  - EXEC→WRITE.
  - WRITE→IDLE.
- Operand and control latching:
  - READ latches rd1→A and the muxed SrcB→B.
  - op, wa3 and we are captured at accept; they are held constant for the rest of the operation.
- EXEC registers result and flags:
  - z = (result==0).
  - neg = result[N-1].
  - Reserved op: result=0, z=1.
- Arithmetic width rules:
  - ADD/SUB wrap modulo 2^N.
  - SUB is computed as A + ~B + 1.
  - SLT: result = 1 if A<B signed, else 0.
- Register 0 always reads 0; writes to it are discarded.
- WRITE edge writes result to wa3 when we=1 and wa3≠0.
- start is ignored while busy=1; there is no queuing.
- Read-after-write: an operation accepted after done sees the value written.
- dbg_rd reflects a write from the cycle after the write edge.

## Timing
- Accept at edge k. READ after k, EXEC after k+1, WRITE after k+2. result and flags are valid from k+2.
- Edge k+3 performs the register write, returns to IDLE and raises done for one cycle.
- Earliest next accept is edge k+4, giving 4 cycles per operation.
- busy is high from after edge k until edge k+3.
- result and flags hold until the next EXEC edge.
- Reset values:
  - All registers 0.
  - State IDLE.
  - busy=0, done=0, result=0.
  - z=1, neg=0, carry=0, ovf=0.
- Reset asserted mid-operation aborts it: no write-back and no done pulse.

## Configuration
- ULA_FLAGS_EN defined:
  - carry = carry-out for ADD and SUB.
  - ovf = signed overflow for ADD and SUB.
  - Both are 0 for the other ops.
- ULA_FLAGS_EN undefined:
  - carry and ovf are tied to 0.
  - No flag logic is synthesised.
- z and neg are always present.

## Structure
- Package ula_pkg holds:
  - Op-code localparams: ULA_AND, ULA_OR, ULA_ADD, ULA_SUB, ULA_SLT.
  - The FSM state enum.
- Sub-module reg_file (params N, NREG):
  - Two async read ports and the debug read port.
  - One synchronous write port.
  - Synchronous active-low clear.
  - Register 0 hardwired to zero.
- ULA logic and FSM are in the top.

## Test plan
All scenarios use N=8, NREG=8.
- Reset then idle: z=1, busy=0, dbg_rd=0 for every address.
- Load r1=0x05 via ADD r0+imm 0x05, we=1, then ADD r1+imm 0x07 → wa3=2:
  - done 3 cycles after accept.
  - result=0x0C, dbg_ra=2 gives 0x0C.
- SUB of r1=0x05 and r2=0x0C → result=0xF9, neg=1, z=0. With ULA_FLAGS_EN: carry=0, ovf=0.
- ADD of 0x7F and imm 0x01 → result=0x80; ovf=1 with ULA_FLAGS_EN, ovf=0 without. Then SLT of 0x80 and 0x01 → result=0x01.
- Write to r0, we=1 → done pulses, r0 still reads 0. start pulsed while busy → ignored, exactly one done.
- rst=0 in EXEC → no write to wa3, no done, all outputs at reset values next cycle.
